// File: rtl/pic_alu_datapath.sv
// Single-cycle PIC-style ALU datapath: instruction decode, file/literal operand
// mux, 8-bit ALU and a registered DATA_W+1-bit result with zero flag.
module pic_alu_datapath #(
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        inst_reg,
  input  logic [DATA_W-1:0] f,
  input  logic [DATA_W-1:0] k,
  input  logic [DATA_W-1:0] w,
  output logic [3:0]        inst,
  output logic              d,
  output logic              switch_a_m,
  output logic [DATA_W-1:0] b,
  output logic [DATA_W:0]   ans,
  output logic              z
);

  localparam int RW   = DATA_W + 1;
  localparam int HALF = DATA_W / 2;

  typedef enum logic [3:0] {
    OP_NOP  = 4'b0000,
    OP_MOV  = 4'b0001,
    OP_ADD  = 4'b0010,
    OP_SUB  = 4'b0011,
    OP_AND  = 4'b0100,
    OP_IOR  = 4'b0101,
    OP_XOR  = 4'b0110,
    OP_COM  = 4'b0111,
    OP_INC  = 4'b1000,
    OP_DEC  = 4'b1001,
    OP_RL   = 4'b1010,
    OP_RR   = 4'b1011,
    OP_SWAP = 4'b1100,
    OP_CLR  = 4'b1101,
    OP_MOVW = 4'b1110,
    OP_SET  = 4'b1111
  } alu_op_e;

  alu_op_e           op;
  logic [DATA_W-1:0] a;
  logic [RW-1:0]     nx;

  // Any instruction outside the ALU group (top bits non-zero) degrades to NOP.
  always_comb begin
    d          = inst_reg[0];
    switch_a_m = inst_reg[5];
    if (inst_reg[7:6] != 2'b00) begin
      op = OP_NOP;
    end else begin
      op = alu_op_e'(inst_reg[4:1]);
    end
  end

  assign inst = op;
  assign a    = w;
  assign b    = switch_a_m ? k : f;

  // SUB is b - a done as b + ~a + 1, so nx[DATA_W] reads as not-borrow.
  always_comb begin
    nx = '0;
    case (op)
      OP_NOP:  nx = '0;
      OP_MOV:  nx = {1'b0, b};
      OP_ADD:  nx = {1'b0, a} + {1'b0, b};
      OP_SUB:  nx = {1'b0, b} + {1'b0, ~a} + RW'(1);
      OP_AND:  nx = {1'b0, a & b};
      OP_IOR:  nx = {1'b0, a | b};
      OP_XOR:  nx = {1'b0, a ^ b};
      OP_COM:  nx = {1'b0, ~b};
      OP_INC:  nx = {1'b0, b} + RW'(1);
      OP_DEC:  nx = {1'b0, b - DATA_W'(1)};
      OP_RL:   nx = {b, 1'b0};
      OP_RR:   nx = {b[0], 1'b0, b[DATA_W-1:1]};
      OP_SWAP: nx = {1'b0, b[HALF-1:0], b[DATA_W-1:HALF]};
      OP_CLR:  nx = '0;
      OP_MOVW: nx = {1'b0, a};
      OP_SET:  nx = {1'b0, {DATA_W{1'b1}}};
      default: nx = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      ans <= '0;
      z   <= 1'b0;
    end else if (op != OP_NOP) begin
      ans <= nx;
      z   <= (nx[DATA_W-1:0] == '0);
    end
  end

endmodule

// File: tb/tb_pic_alu_datapath.sv
// Self-checking bench for pic_alu_datapath: directed steps then randomized
// operations, all compared against an arithmetic reference model.
module tb_pic_alu_datapath;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] inst_reg, f, k, w;
  logic [3:0] inst;
  logic       d, switch_a_m;
  logic [7:0] b;
  logic [8:0] ans;
  logic       z;

  int   n_pass = 0;
  int   n_total = 0;
  logic [8:0] m_ans = '0;
  logic       m_z = 1'b0;
  bit         model_valid = 1'b0;

  always #5 clk = ~clk;

  pic_alu_datapath #(.DATA_W(8)) dut (
    .clk(clk), .reset(reset), .inst_reg(inst_reg), .f(f), .k(k), .w(w),
    .inst(inst), .d(d), .switch_a_m(switch_a_m), .b(b), .ans(ans), .z(z)
  );

  task automatic check(input string tag, input logic [8:0] obs, input logic [8:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("[TB] FAIL %s: observed %0h required %0h", tag, obs, exp);
  endtask

  // Reference results from plain integer arithmetic, modulo 512.
  function automatic logic [8:0] ref_alu(input int op, input int a, input int bv);
    int r;
    case (op)
      1:  r = bv;
      2:  r = a + bv;
      3:  r = 256 + bv - a;
      4:  r = a & bv;
      5:  r = a | bv;
      6:  r = a ^ bv;
      7:  r = 255 - bv;
      8:  r = bv + 1;
      9:  r = (bv + 255) % 256;
      10: r = bv * 2;
      11: r = (bv / 2) + (bv % 2) * 256;
      12: r = (bv % 16) * 16 + bv / 16;
      13: r = 0;
      14: r = a;
      15: r = 255;
      default: r = 0;
    endcase
    return 9'(r % 512);
  endfunction

  task automatic step(input logic [7:0] ir, input logic [7:0] fv, input logic [7:0] kv,
                      input logic [7:0] wv, input logic rst_n, input string tag);
    int op;
    int bv;
    @(negedge clk);
    inst_reg = ir;
    f        = fv;
    k        = kv;
    w        = wv;
    reset    = rst_n;
    #1;
    op = (ir[7:6] != 2'b00) ? 0 : int'(ir[4:1]);
    bv = ir[5] ? int'(kv) : int'(fv);
    check({tag, ".inst"}, 9'(inst), 9'(op));
    check({tag, ".d"}, 9'(d), 9'(ir[0]));
    check({tag, ".sel"}, 9'(switch_a_m), 9'(ir[5]));
    check({tag, ".b"}, 9'(b), 9'(bv));
    if (model_valid) check({tag, ".ans_pre"}, ans, m_ans);
    if (!rst_n) begin
      m_ans = '0;
      m_z   = 1'b0;
    end else if (op != 0) begin
      m_ans = ref_alu(op, int'(wv), bv);
      m_z   = (m_ans[7:0] == 8'h00);
    end
    model_valid = 1'b1;
    @(posedge clk);
    #1;
    check({tag, ".ans"}, ans, m_ans);
    check({tag, ".z"}, 9'(z), 9'(m_z));
  endtask

  initial begin
    reset = 1'b0;
    inst_reg = '0; f = '0; k = '0; w = '0;

    step(8'h37, 8'h12, 8'h34, 8'h56, 1'b0, "reset");
    check("reset_const", ans, 9'h000);
    step(8'h01, 8'h33, 8'h44, 8'h55, 1'b1, "nop");
    check("nop_const", ans, 9'h000);

    step(8'h05, 8'd10, 8'd0, 8'd25, 1'b1, "add35");
    check("add35_const", ans, 9'd35);
    for (int i = 0; i < 3; i++) step(8'h59, 8'hFF, 8'hFF, 8'hFF, 1'b1, "reserved_hold");
    check("hold_const", ans, 9'd35);
    step(8'h1D, 8'd0, 8'd0, 8'd7, 1'b1, "movw");
    check("movw_const", ans, 9'd7);

    step(8'h05, 8'd200, 8'd0, 8'd56, 1'b1, "add_carry");
    check("add_carry_const", ans, 9'h100);
    check("add_carry_z", 9'(z), 9'd1);
    step(8'h07, 8'd10, 8'd0, 8'd10, 1'b1, "sub_eq");
    check("sub_eq_const", ans, 9'h100);
    step(8'h07, 8'd5, 8'd0, 8'd10, 1'b1, "sub_borrow");
    check("sub_borrow_const", ans, 9'h0FB);
    step(8'h25, 8'd0, 8'd200, 8'd100, 1'b1, "literal");
    check("literal_const", ans, 9'h12C);
    step(8'h19, 8'hA5, 8'h00, 8'h00, 1'b1, "swap");
    check("swap_const", ans, 9'h05A);
    step(8'h15, 8'h81, 8'h00, 8'h00, 1'b1, "rl");
    check("rl_const", ans, 9'h102);
    step(8'h13, 8'h00, 8'h00, 8'h00, 1'b1, "dec");
    check("dec_const", ans, 9'h0FF);
    step(8'h11, 8'hFF, 8'h00, 8'h00, 1'b1, "inc_wrap");
    check("inc_wrap_const", ans, 9'h100);
    step(8'h17, 8'h81, 8'h00, 8'h00, 1'b1, "rr");
    check("rr_const", ans, 9'h140);

    // Mid-stream reset clears on its own edge, then operation resumes.
    step(8'h1F, 8'h00, 8'h00, 8'h00, 1'b1, "set");
    step(8'h1F, 8'h00, 8'h00, 8'h00, 1'b0, "mid_reset");
    check("mid_reset_const", ans, 9'h000);

    for (int i = 0; i < 400; i++) begin
      step(8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom),
           ($urandom_range(0, 19) != 0), "rand");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
